io_port_bank: RTL and testbench
===============================

Name: io_port_bank

Overview:
- Peripheral responder on the command-controlled device's port bus. It answers the device's port_read and port_write strobes on 8 port addresses.
- Provides:
  - four 4-bit GPIO output registers
  - a receive FIFO fed by an external valid/ready source
  - a status register
  - a prescaled down-counter timer
  - a scratch register
- Sits beside the command-controlled device. Its rd_data drives the device's data_in; its wr_data is the device's data_out.

Parameters:
- FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.
- PRESCALE, 16, clock cycles per timer decrement; must be at least 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- port_id  input  3  port address from the device.
- port_read  input  1  read strobe, one cycle per access.
- port_write  input  1  write strobe, one cycle per access.
- wr_data  input  4  write data (the device's data_out).
- rd_data  output  4  read data (to the device's data_in); combinational.
- gpio_out  output  16  GPIO registers; nibble n = port n.
- ext_data  input  4  external receive data.
- ext_valid  input  1  external data valid.
- ext_ready  output  1  FIFO can accept; equals ~fifo_full.
- timer_tick  output  1  one-cycle pulse when the timer reaches 0.

Behaviour:
- Reset (reset low, asynchronous):
  - all GPIO, scratch, timer count, prescaler, overflow and expired flags go to 0
  - FIFO pointers and count go to 0 (empty)
  - timer_tick = 0, ext_ready = 1
- Write access: when port_write=1 at a rising edge, wr_data is captured into the port addressed by port_id.
- Read access:
  - rd_data = contents of the addressed port while port_read=1, else 0.
  - Any side effect of a read happens at the rising edge where port_read=1.
- Simultaneous read and write: rd_data shows the pre-write value. The write and the read side effect both take place at the same edge.
- Port map:
  - 0-3: GPIO nibble n, read/write; the read returns the register value.
  - 4: FIFO head, read-only.
    - A read when not empty returns the head and pops it.
    - A read when empty returns 0 and does not pop.
    - Writes are ignored.
  - 5: status. Read returns {expired, fifo_full, fifo_empty, overflow} (bit3..bit0). On write:
    - wr_data[0]=1 clears overflow
    - wr_data[3]=1 clears expired
    - other bits are ignored
  - 6: timer. A write loads the count with wr_data and resets the prescaler to 0. A read returns the current count.
  - 7: scratch, read/write.
- FIFO:
  - Push when ext_valid & ext_ready at an edge.
  - Storage is circular; the pointers wrap modulo FIFO_DEPTH.
  - ext_ready = ~full. While full, ext_valid=1 sets overflow, which is sticky, and the data is discarded.
  - Push and pop in the same edge: count is unchanged and both pointers advance.
  - Read of port 4 while empty plus a push at the same edge: rd_data=0, count becomes 1.
  - Overflow set and a clear write at the same edge: the set wins.
- Timer:
  - The prescaler counts 0..PRESCALE-1 and wraps.
  - At the wrap edge, if count != 0, count decrements.
  - A decrement from 1 to 0 sets expired and asserts timer_tick for exactly the next cycle.
  - Count 0 is idle: no ticks, but the prescaler keeps running.
  - A port-6 write at the same edge as a wrap: the write wins, with no decrement.
  - Expired set and a clear write at the same edge: the set wins.
- The counter is 4 bits with no underflow; it holds at 0.
- Reset mid-operation aborts everything immediately. The FIFO contents are discarded.

Test Plan:
- Reset, then write 0xA to port 2 and 0x5 to port 7; read both -> rd_data 0xA and 0x5; gpio_out=0x0A00.
- Push 3,7,9 via ext_valid; read port 4 three times -> 3,7,9. A fourth read -> 0 with no pop. Status reads 0x2 (empty).
- With FIFO_DEPTH=4, push 4 items -> ext_ready=0, status 0x4. Drive a fifth ext_valid -> status 0x5. Write 0x1 to port 5 -> status 0x4. Contents remain intact.
- Write 2 to port 6 with PRESCALE=16:
  - read port 6 after 16 cycles -> 1
  - timer_tick pulses one cycle at about 32 cycles
  - status bit3=1
  - write 0x8 to port 5 -> bit3=0
- With the FIFO full, assert a port-4 read and ext_valid together -> head returned, no push (ready was 0), count 3. Next cycle ext_ready=1.
- Assert reset low mid-timer with the FIFO at 2 entries -> all outputs 0 asynchronously, status 0x2 after release, timer_tick never pulses.

Source files
------------

// File: rtl/io_port_bank.sv
// io_port_bank
// Port-bus responder for the command-controlled device. Decodes eight port
// addresses and answers one-cycle read/write strobes.
//
//   port | access | contents
//   0-3  | r/w    | GPIO nibble n (gpio_out[4n+3:4n])
//   4    | r      | receive FIFO head; a read pops when not empty
//   5    | r/w1c  | status {expired, fifo_full, fifo_empty, overflow}
//   6    | r/w    | timer count; a write also restarts the prescaler
//   7    | r/w    | scratch
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   port_id            port address
//   port_read/write    one-cycle access strobes
//   wr_data, rd_data   write data in, combinational read data out
//   gpio_out           the four GPIO nibbles
//   ext_data/valid     external receive source
//   ext_ready          FIFO not full
//   timer_tick         one-cycle pulse after the timer decrements to 0

module io_port_bank #(
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  port_id,
    input  logic        port_read,
    input  logic        port_write,
    input  logic [3:0]  wr_data,
    output logic [3:0]  rd_data,
    output logic [15:0] gpio_out,
    input  logic [3:0]  ext_data,
    input  logic        ext_valid,
    output logic        ext_ready,
    output logic        timer_tick
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    localparam logic [2:0] PORT_FIFO    = 3'd4;
    localparam logic [2:0] PORT_STATUS  = 3'd5;
    localparam logic [2:0] PORT_TIMER   = 3'd6;
    localparam logic [2:0] PORT_SCRATCH = 3'd7;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [7:0] wr_sel;
    logic [7:0] rd_sel;

    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        if (port_write) wr_sel[port_id] = 1'b1;
        if (port_read)  rd_sel[port_id] = 1'b1;
    end

    // ------------------------------------------------------------------
    // GPIO and scratch registers
    // ------------------------------------------------------------------
    logic [15:0] gpio_q;
    logic [3:0]  scratch_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gpio_q    <= '0;
            scratch_q <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (wr_sel[n]) gpio_q[n*4 +: 4] <= wr_data;
            end
            if (wr_sel[PORT_SCRATCH]) scratch_q <= wr_data;
        end
    end

    assign gpio_out = gpio_q;

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [3:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             overflow_q;
    logic             overflow_set;

    assign fifo_full    = (fifo_count == DEPTH_C);
    assign fifo_empty   = (fifo_count == '0);
    assign ext_ready    = ~fifo_full;
    // Readiness is judged before this edge's pop, so a full FIFO refuses
    // data even while the head is being read out.
    assign push         = ext_valid & ~fifo_full;
    assign pop          = rd_sel[PORT_FIFO] & ~fifo_empty;
    assign overflow_set = ext_valid & fifo_full;

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= ext_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            // Depth is a power of two, so pointer wrap is natural rollover.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (overflow_set) begin
            overflow_q <= 1'b1;
        end else if (wr_sel[PORT_STATUS] && wr_data[0]) begin
            overflow_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Prescaled timer
    // ------------------------------------------------------------------
    logic [PS_W-1:0] prescale_q;
    logic            ps_wrap;
    logic [3:0]      timer_count;
    logic            timer_load;
    logic            expire;
    logic            expired_q;
    logic            tick_q;

    assign ps_wrap    = (prescale_q == PS_LAST);
    assign timer_load = wr_sel[PORT_TIMER];
    // A load on the wrap edge takes priority and suppresses the decrement.
    assign expire     = ~timer_load & ps_wrap & (timer_count == 4'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescale_q  <= '0;
            timer_count <= '0;
            tick_q      <= 1'b0;
        end else begin
            tick_q <= expire;
            if (timer_load) begin
                prescale_q  <= '0;
                timer_count <= wr_data;
            end else begin
                prescale_q <= ps_wrap ? '0 : prescale_q + PS_W'(1);
                if (ps_wrap && timer_count != 4'd0) begin
                    timer_count <= timer_count - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            expired_q <= 1'b0;
        end else if (expire) begin
            expired_q <= 1'b1;
        end else if (wr_sel[PORT_STATUS] && wr_data[3]) begin
            expired_q <= 1'b0;
        end
    end

    assign timer_tick = tick_q;

    // ------------------------------------------------------------------
    // Read mux: shows pre-edge contents, so a simultaneous write is not
    // visible until the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        if (port_read) begin
            case (port_id)
                3'd0:         rd_data = gpio_q[3:0];
                3'd1:         rd_data = gpio_q[7:4];
                3'd2:         rd_data = gpio_q[11:8];
                3'd3:         rd_data = gpio_q[15:12];
                PORT_FIFO:    rd_data = fifo_empty ? 4'd0 : fifo_mem[rd_ptr];
                PORT_STATUS:  rd_data = {expired_q, fifo_full, fifo_empty, overflow_q};
                PORT_TIMER:   rd_data = timer_count;
                default:      rd_data = scratch_q;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank
// Directed scenarios plus a randomized run, all checked against a queue-based
// behavioural model of the port bank that is advanced once per clock edge.

module tb_io_port_bank;

    localparam int FIFO_DEPTH = 4;
    localparam int PRESCALE   = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  port_id = '0;
    logic        port_read = 1'b0;
    logic        port_write = 1'b0;
    logic [3:0]  wr_data = '0;
    logic [3:0]  ext_data = '0;
    logic        ext_valid = 1'b0;
    logic [3:0]  rd_data;
    logic [15:0] gpio_out;
    logic        ext_ready;
    logic        timer_tick;

    io_port_bank #(.FIFO_DEPTH(FIFO_DEPTH), .PRESCALE(PRESCALE)) dut (
        .clock      (clock),
        .reset      (reset),
        .port_id    (port_id),
        .port_read  (port_read),
        .port_write (port_write),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .gpio_out   (gpio_out),
        .ext_data   (ext_data),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .timer_tick (timer_tick)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    logic [3:0] m_gpio [4];
    logic [3:0] m_scratch;
    int         m_count;
    int         m_pre;
    bit         m_ovf;
    bit         m_exp;
    bit         m_tick;
    logic [3:0] m_q [$];

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_gpio[i] = '0;
        m_scratch = '0;
        m_count   = 0;
        m_pre     = 0;
        m_ovf     = 0;
        m_exp     = 0;
        m_tick    = 0;
        m_q.delete();
    endfunction

    function automatic logic [15:0] m_gpio_word();
        return {m_gpio[3], m_gpio[2], m_gpio[1], m_gpio[0]};
    endfunction

    function automatic logic [3:0] m_status();
        return {m_exp, (m_q.size() == FIFO_DEPTH), (m_q.size() == 0), m_ovf};
    endfunction

    function automatic logic [3:0] m_read();
        if (!port_read) return 4'd0;
        case (port_id)
            3'd0, 3'd1, 3'd2, 3'd3: return m_gpio[port_id[1:0]];
            3'd4:    return (m_q.size() != 0) ? m_q[0] : 4'd0;
            3'd5:    return m_status();
            3'd6:    return 4'(m_count);
            default: return m_scratch;
        endcase
    endfunction

    function automatic void model_update();
        bit full   = (m_q.size() == FIFO_DEPTH);
        bit wrap   = (m_pre == PRESCALE - 1);
        bit wr6    = port_write && (port_id == 3'd6);
        bit clr5   = port_write && (port_id == 3'd5);
        bit expire = 0;
        if (ext_valid && full) m_ovf = 1;
        else if (clr5 && wr_data[0]) m_ovf = 0;
        if (port_read && port_id == 3'd4 && m_q.size() != 0) void'(m_q.pop_front());
        if (ext_valid && !full) m_q.push_back(ext_data);
        m_pre = (wr6 || wrap) ? 0 : m_pre + 1;
        if (wr6) begin
            m_count = int'(wr_data);
        end else if (wrap && m_count > 0) begin
            m_count = m_count - 1;
            expire  = (m_count == 0);
        end
        m_tick = expire;
        if (expire) m_exp = 1;
        else if (clr5 && wr_data[3]) m_exp = 0;
        if (port_write && port_id < 3'd4) m_gpio[port_id[1:0]] = wr_data;
        if (port_write && port_id == 3'd7) m_scratch = wr_data;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        if (!reset) model_reset();
        else model_update();
        @(negedge clock);
    endtask

    task automatic drive(input logic [2:0] pid, input bit rd, input bit wr,
                         input logic [3:0] wd, input bit ev, input logic [3:0] ed);
        port_id    = pid;
        port_read  = rd;
        port_write = wr;
        wr_data    = wd;
        ext_valid  = ev;
        ext_data   = ed;
        #1;
    endtask

    task automatic idle();
        drive(3'd0, 0, 0, 4'd0, 0, 4'd0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(3'd5, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (gpio_out !== 16'h0000) begin
            n_err++; $display("FAIL reset_gpio: got %h expected 0000", gpio_out);
        end
        n_vec++;
        if (timer_tick !== 1'b0) begin
            n_err++; $display("FAIL reset_tick: got %b expected 0", timer_tick);
        end
        n_vec++;
        if (ext_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b expected 1", ext_ready);
        end
        n_vec++;
        if (rd_data !== 4'h2) begin
            n_err++; $display("FAIL reset_status: got %h expected 2", rd_data);
        end
        reset = 1'b1;
        idle();
        step();
    endtask

    task automatic test_gpio_scratch();
        drive(3'd2, 0, 1, 4'hA, 0, 4'd0); step();
        drive(3'd7, 0, 1, 4'h5, 0, 4'd0); step();
        drive(3'd2, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (rd_data !== 4'hA) begin
            n_err++; $display("FAIL gpio2_read: got %h expected a", rd_data);
        end
        step();
        drive(3'd7, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (rd_data !== 4'h5) begin
            n_err++; $display("FAIL scratch_read: got %h expected 5", rd_data);
        end
        n_vec++;
        if (gpio_out !== 16'h0A00) begin
            n_err++; $display("FAIL gpio_word: got %h expected 0a00", gpio_out);
        end
        step();
        // read and write of the same port in one cycle shows the old value
        drive(3'd7, 1, 1, 4'hC, 0, 4'd0);
        n_vec++;
        if (rd_data !== 4'h5) begin
            n_err++; $display("FAIL scratch_rw_same_edge: got %h expected 5", rd_data);
        end
        step();
        drive(3'd7, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (rd_data !== 4'hC) begin
            n_err++; $display("FAIL scratch_after_rw: got %h expected c", rd_data);
        end
        step();
    endtask

    task automatic test_fifo_basic();
        logic [3:0] vals [3];
        vals[0] = 4'd3; vals[1] = 4'd7; vals[2] = 4'd9;
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, 0, 0, 4'd0, 1, vals[i]); step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(3'd4, 1, 0, 4'd0, 0, 4'd0);
            n_vec++;
            if (rd_data !== vals[i]) begin
                n_err++; $display("FAIL fifo_pop%0d: got %h expected %h", i, rd_data, vals[i]);
            end
            step();
        end
        drive(3'd4, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (rd_data !== 4'd0) begin
            n_err++; $display("FAIL fifo_empty_read: got %h expected 0", rd_data);
        end
        step();
        drive(3'd5, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (rd_data !== 4'h2) begin
            n_err++; $display("FAIL fifo_empty_status: got %h expected 2", rd_data);
        end
        step();
    endtask

    task automatic test_fifo_overflow();
        logic [3:0] vals [FIFO_DEPTH];
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            vals[i] = 4'($urandom_range(0, 15));
            drive(3'd0, 0, 0, 4'd0, 1, vals[i]); step();
        end
        drive(3'd5, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (ext_ready !== 1'b0) begin
            n_err++; $display("FAIL full_ready: got %b expected 0", ext_ready);
        end
        n_vec++;
        if (rd_data !== 4'h4) begin
            n_err++; $display("FAIL full_status: got %h expected 4", rd_data);
        end
        step();
        drive(3'd0, 0, 0, 4'd0, 1, ~vals[0]); step();
        drive(3'd5, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (rd_data !== 4'h5) begin
            n_err++; $display("FAIL overflow_status: got %h expected 5", rd_data);
        end
        step();
        drive(3'd5, 0, 1, 4'h1, 0, 4'd0); step();
        drive(3'd5, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (rd_data !== 4'h4) begin
            n_err++; $display("FAIL overflow_clear: got %h expected 4", rd_data);
        end
        step();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            drive(3'd4, 1, 0, 4'd0, 0, 4'd0);
            n_vec++;
            if (rd_data !== vals[i]) begin
                n_err++; $display("FAIL overflow_contents%0d: got %h expected %h", i, rd_data, vals[i]);
            end
            step();
        end
    endtask

    task automatic test_timer();
        int cnt;
        drive(3'd6, 0, 1, 4'd2, 0, 4'd0); step();
        repeat (16) begin idle(); step(); end
        drive(3'd6, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (rd_data !== 4'd1) begin
            n_err++; $display("FAIL timer_after16: got %h expected 1", rd_data);
        end
        step();
        cnt = 17;
        idle();
        while (cnt < 40 && timer_tick !== 1'b1) begin
            step(); cnt++;
        end
        n_vec++;
        if (cnt != 32 || timer_tick !== 1'b1) begin
            n_err++; $display("FAIL timer_tick_time: got cycle %0d tick %b expected cycle 32 tick 1", cnt, timer_tick);
        end
        step();
        drive(3'd5, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (timer_tick !== 1'b0) begin
            n_err++; $display("FAIL timer_tick_width: got %b expected 0", timer_tick);
        end
        n_vec++;
        if (rd_data !== 4'hA) begin
            n_err++; $display("FAIL timer_expired_status: got %h expected a", rd_data);
        end
        step();
        drive(3'd5, 0, 1, 4'h8, 0, 4'd0); step();
        drive(3'd5, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (rd_data[3] !== 1'b0) begin
            n_err++; $display("FAIL timer_expired_clear: got %b expected 0", rd_data[3]);
        end
        step();
    endtask

    task automatic test_full_pop_push();
        logic [3:0] vals [FIFO_DEPTH];
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            vals[i] = 4'($urandom_range(0, 15));
            drive(3'd0, 0, 0, 4'd0, 1, vals[i]); step();
        end
        drive(3'd4, 1, 0, 4'd0, 1, ~vals[0]);
        n_vec++;
        if (rd_data !== vals[0]) begin
            n_err++; $display("FAIL fullpop_head: got %h expected %h", rd_data, vals[0]);
        end
        step();
        drive(3'd5, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (ext_ready !== 1'b1) begin
            n_err++; $display("FAIL fullpop_ready: got %b expected 1", ext_ready);
        end
        // count 3, and the refused ext_valid marked overflow
        n_vec++;
        if (rd_data !== 4'h1) begin
            n_err++; $display("FAIL fullpop_status: got %h expected 1", rd_data);
        end
        step();
        for (int i = 1; i < FIFO_DEPTH; i++) begin
            drive(3'd4, 1, 0, 4'd0, 0, 4'd0);
            n_vec++;
            if (rd_data !== vals[i]) begin
                n_err++; $display("FAIL fullpop_rest%0d: got %h expected %h", i, rd_data, vals[i]);
            end
            step();
        end
        drive(3'd5, 0, 1, 4'h1, 0, 4'd0); step();
    endtask

    task automatic test_random();
        logic [2:0] pid;
        for (int i = 0; i < 600; i++) begin
            pid = 3'($urandom_range(0, 7));
            drive(pid, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  (pid == 3'd6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)));
            n_vec++;
            if (rd_data !== m_read()) begin
                n_err++; $display("FAIL rand_rd_data[%0d]: got %h expected %h", i, rd_data, m_read());
            end
            n_vec++;
            if (gpio_out !== m_gpio_word()) begin
                n_err++; $display("FAIL rand_gpio[%0d]: got %h expected %h", i, gpio_out, m_gpio_word());
            end
            n_vec++;
            if (ext_ready !== (m_q.size() != FIFO_DEPTH)) begin
                n_err++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, ext_ready, m_q.size() != FIFO_DEPTH);
            end
            n_vec++;
            if (timer_tick !== m_tick) begin
                n_err++; $display("FAIL rand_tick[%0d]: got %b expected %b", i, timer_tick, m_tick);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20 && m_q.size() != 0; i++) begin
            drive(3'd4, 1, 0, 4'd0, 0, 4'd0); step();
        end
        drive(3'd0, 0, 1, 4'hF, 0, 4'd0); step();
        drive(3'd5, 0, 1, 4'h9, 0, 4'd0); step();
        drive(3'd0, 0, 0, 4'd0, 1, 4'h6); step();
        drive(3'd0, 0, 0, 4'd0, 1, 4'h3); step();
        drive(3'd6, 0, 1, 4'd1, 0, 4'd0); step();
        repeat (5) begin idle(); step(); end
        idle();
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (gpio_out !== 16'h0000) begin
            n_err++; $display("FAIL midreset_gpio: got %h expected 0000", gpio_out);
        end
        n_vec++;
        if (timer_tick !== 1'b0 || rd_data !== 4'd0) begin
            n_err++; $display("FAIL midreset_outputs: got tick %b rd %h expected tick 0 rd 0", timer_tick, rd_data);
        end
        n_vec++;
        if (ext_ready !== 1'b1) begin
            n_err++; $display("FAIL midreset_ready: got %b expected 1", ext_ready);
        end
        step();
        step();
        reset = 1'b1;
        drive(3'd5, 1, 0, 4'd0, 0, 4'd0);
        n_vec++;
        if (rd_data !== 4'h2) begin
            n_err++; $display("FAIL midreset_status: got %h expected 2", rd_data);
        end
        step();
        idle();
        for (int i = 0; i < 40; i++) begin
            n_vec++;
            if (timer_tick !== 1'b0) begin
                n_err++; $display("FAIL midreset_no_tick[%0d]: got %b expected 0", i, timer_tick);
            end
            step();
        end
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        test_reset();
        test_gpio_scratch();
        test_fifo_basic();
        test_fifo_overflow();
        test_timer();
        test_full_pop_push();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
